data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 43 ++++
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder_dmem_bank.sv | 41 ++++
 rtl/data_mem_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access codes, FSM
// encoding, default RAM depth and small decode helpers used by the core's
// memory-access stage and by the responder itself.
package data_mem_responder_pkg;

    localparam int WE_WIDTH        = 3;
    localparam int DMEM_DEPTH_LOG2 = 12;

    localparam logic [WE_WIDTH-1:0] WE_LOAD = 3'b000;
    localparam logic [WE_WIDTH-1:0] WE_SB   = 3'b001;
    localparam logic [WE_WIDTH-1:0] WE_SH   = 3'b010;
    localparam logic [WE_WIDTH-1:0] WE_SW   = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } dmem_state_e;

    // Byte lanes touched by an access of this code, before alignment.
    // Loads always fetch four bytes; illegal codes touch nothing.
    function automatic logic [3:0] lane_mask(input logic [WE_WIDTH-1:0] we);
        logic [3:0] mask;
        case (we)
            WE_LOAD: mask = 4'b1111;
            WE_SB:   mask = 4'b0001;
            WE_SH:   mask = 4'b0011;
            WE_SW:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // True for the four defined access codes.
    function automatic logic we_legal(input logic [WE_WIDTH-1:0] we);
        logic ok;
        case (we)
            WE_LOAD, WE_SB, WE_SH, WE_SW: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory port between the core's memory-access stage (master) and the
// responder (slave).
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
);
    logic                mem_req;
    logic [AWIDTH-1:0]   data_mem_addr;
    logic [XLEN-1:0]     data_mem_wdata;
    logic [WE_WIDTH-1:0] data_mem_we;
    logic [XLEN-1:0]     data_mem_out;
    logic                mem_busy;
    logic                mem_err;

    modport master (
        output mem_req, data_mem_addr, data_mem_wdata, data_mem_we,
        input  data_mem_out, mem_busy, mem_err
    );

    modport slave (
        input  mem_req, data_mem_addr, data_mem_wdata, data_mem_we,
        output data_mem_out, mem_busy, mem_err
    );
endinterface

// File: rtl/data_mem_responder_dmem_bank.sv
// dmem_bank: single-port synchronous RAM of 32-bit words built from four
// byte lanes with individual write enables and a registered read that holds
// its value whenever no read is requested.
module data_mem_responder_dmem_bank #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [3:0][7:0] mem_r [0:(1<<DEPTH_LOG2)-1];
    logic [31:0]     rdata_r;

    // Per-lane byte writes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_r[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read port, held between reads so the last load stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port. Serves byte/half/word stores
// and word loads from an on-chip RAM; accesses crossing a word boundary take
// two RAM cycles and raise mem_busy so the core stalls. Out-of-range words
// and illegal access codes set the sticky mem_err flag.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AWIDTH     = 32,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);

    dmem_state_e           state_r;
    dmem_state_e           state_nxt_s;

    logic [AWIDTH-1:0]     cap_addr_r;
    logic [WE_WIDTH-1:0]   cap_we_r;
    logic [XLEN-1:0]       cap_wdata_r;

    logic [AWIDTH-1:0]     cur_addr_s;
    logic [WE_WIDTH-1:0]   cur_we_s;
    logic [XLEN-1:0]       cur_wdata_s;

    logic [1:0]            off_s;
    logic [DEPTH_LOG2-1:0] word_s;
    logic                  ok0_s;
    logic                  ok1_s;
    logic [7:0]            lane64_s;
    logic [2*XLEN-1:0]     data64_s;
    logic                  split_s;
    logic                  is_load_s;
    logic                  legal_s;

    logic [DEPTH_LOG2-1:0] bank_addr_s;
    logic                  bank_re_s;
    logic [3:0]            bank_we_s;
    logic [XLEN-1:0]       bank_wdata_s;
    logic [XLEN-1:0]       rdata_s;

    logic                  busy_s;
    logic                  err_set_s;
    logic                  accept_s;
    logic                  load_first_s;
    logic                  load_second_s;
    logic                  err_r;

    logic [1:0]            ld_off_r;
    logic                  ld_split_r;
    logic                  lo_ok_r;
    logic                  hi_ok_r;
    logic [XLEN-1:0]       lo_word_r;
    logic [XLEN-1:0]       lo_s;
    logic [XLEN-1:0]       hi_s;
    logic [XLEN-1:0]       out_s;

    // Work on live inputs when idle, on the captured request during the second half.
    always_comb begin
        if (state_r == ST_SECOND) begin
            cur_addr_s  = cap_addr_r;
            cur_we_s    = cap_we_r;
            cur_wdata_s = cap_wdata_r;
        end else begin
            cur_addr_s  = bus.data_mem_addr;
            cur_we_s    = bus.data_mem_we;
            cur_wdata_s = bus.data_mem_wdata;
        end
    end

    // Lane positions over the two-word window starting at word W.
    assign off_s     = cur_addr_s[1:0];
    assign word_s    = cur_addr_s[DEPTH_LOG2+1:2];
    assign ok0_s     = (cur_addr_s[AWIDTH-1:DEPTH_LOG2+2] == '0);
    assign ok1_s     = ok0_s && (word_s != '1);
    assign lane64_s  = {4'b0000, lane_mask(cur_we_s)} << off_s;
    assign data64_s  = {{XLEN{1'b0}}, cur_wdata_s} << {off_s, 3'b000};
    assign split_s   = |lane64_s[7:4];
    assign is_load_s = (cur_we_s == WE_LOAD);
    assign legal_s   = we_legal(cur_we_s);

    // FSM next state plus RAM port control for first and second halves.
    always_comb begin
        state_nxt_s   = state_r;
        bank_addr_s   = word_s;
        bank_re_s     = 1'b0;
        bank_we_s     = 4'b0000;
        bank_wdata_s  = data64_s[XLEN-1:0];
        busy_s        = 1'b0;
        err_set_s     = 1'b0;
        accept_s      = 1'b0;
        load_first_s  = 1'b0;
        load_second_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst && bus.mem_req) begin
                    accept_s = 1'b1;
                    if (!legal_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = !ok0_s;
                        if (is_load_s) begin
                            bank_re_s    = 1'b1;
                            load_first_s = 1'b1;
                        end else begin
                            bank_we_s = ok0_s ? lane64_s[3:0] : 4'b0000;
                        end
                        if (split_s) begin
                            state_nxt_s = ST_SECOND;
                            busy_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SECOND: begin
                busy_s       = 1'b1;
                state_nxt_s  = ST_IDLE;
                bank_addr_s  = word_s + DEPTH_LOG2'(1);
                bank_wdata_s = data64_s[2*XLEN-1:XLEN];
                // A reset here drops the pending half; the first half stays written.
                if (!rst) begin
                    err_set_s = !ok1_s;
                    if (is_load_s) begin
                        bank_re_s     = 1'b1;
                        load_second_s = 1'b1;
                    end else begin
                        bank_we_s = ok1_s ? lane64_s[7:4] : 4'b0000;
                    end
                end else begin
                    bank_we_s = 4'b0000;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the accepted request so the second half can proceed unattended.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr_r  <= {AWIDTH{1'b0}};
            cap_we_r    <= WE_LOAD;
            cap_wdata_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            cap_addr_r  <= bus.data_mem_addr;
            cap_we_r    <= bus.data_mem_we;
            cap_wdata_r <= bus.data_mem_wdata;
        end else begin
            cap_addr_r  <= cap_addr_r;
            cap_we_r    <= cap_we_r;
            cap_wdata_r <= cap_wdata_r;
        end
    end

    // Remember how the most recent load is assembled; keep its first word when split.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_off_r   <= 2'b00;
            ld_split_r <= 1'b0;
            lo_ok_r    <= 1'b0;
            hi_ok_r    <= 1'b0;
            lo_word_r  <= {XLEN{1'b0}};
        end else begin
            if (load_first_s) begin
                ld_off_r   <= off_s;
                ld_split_r <= split_s;
                lo_ok_r    <= ok0_s;
                hi_ok_r    <= ok1_s;
            end else begin
                ld_off_r   <= ld_off_r;
                ld_split_r <= ld_split_r;
                lo_ok_r    <= lo_ok_r;
                hi_ok_r    <= hi_ok_r;
            end
            if (load_second_s) begin
                lo_word_r <= lo_ok_r ? rdata_s : {XLEN{1'b0}};
            end else begin
                lo_word_r <= lo_word_r;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Right-justify the load window from registered RAM data; out-of-range words read as zero.
    always_comb begin
        lo_s = {XLEN{1'b0}};
        hi_s = {XLEN{1'b0}};
        if (ld_split_r) begin
            lo_s = lo_word_r;
            hi_s = hi_ok_r ? rdata_s : {XLEN{1'b0}};
        end else begin
            lo_s = lo_ok_r ? rdata_s : {XLEN{1'b0}};
            hi_s = {XLEN{1'b0}};
        end
        out_s = XLEN'({hi_s, lo_s} >> {ld_off_r, 3'b000});
    end

    data_mem_responder_dmem_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dmem_bank (
        .clk   (clk),
        .rst   (rst),
        .addr  (bank_addr_s),
        .re    (bank_re_s),
        .we    (bank_we_s),
        .wdata (bank_wdata_s),
        .rdata (rdata_s)
    );

    assign bus.data_mem_out = out_s;
    assign bus.mem_busy     = busy_s;
    assign bus.mem_err      = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a table of load/store vectors applied
// back-to-back with a scoreboard of expected read data, plus hand-written
// sequences for strobe-while-busy, illegal codes, range errors and reset in
// the middle of a split access.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_mem_responder_if #(.XLEN(32), .AWIDTH(32)) bus ();

    data_mem_responder #(.XLEN(32), .AWIDTH(32), .DEPTH_LOG2(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [31:0] msk;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] msk;
    } sb_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = 32'h0;
    logic [31:0] last_msk = 32'hFFFF_FFFF;
    logic        err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one request (called just after a falling edge) and walk it to completion.
    task automatic issue(input string name, input logic [2:0] we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp, input logic [31:0] msk);
        int   n;
        logic legal;
        logic split;
        logic oor0;
        logic oor1;
        sb_t  e;
        legal = (we == WE_LOAD) || (we == WE_SB) || (we == WE_SH) || (we == WE_SW);
        n     = (we == WE_SB) ? 1 : ((we == WE_SH) ? 2 : 4);
        split = legal && ((int'(addr[1:0]) + n) > 4);
        oor0  = (addr >= 32'h0000_4000);
        oor1  = (((addr >> 2) + 32'd1) >= 32'h0000_1000);
        if (legal && we == WE_LOAD) begin
            e.exp = exp & msk;
            e.msk = msk;
            last_exp = e.exp;
            last_msk = msk;
        end else begin
            e.exp = last_exp;
            e.msk = last_msk;
        end
        sb_q.push_back(e);
        bus.mem_req        = 1'b1;
        bus.data_mem_we    = we;
        bus.data_mem_addr  = addr;
        bus.data_mem_wdata = wd;
        #1;
        check({name, "/busy_T"}, {31'd0, bus.mem_busy}, {31'd0, split});
        @(negedge clk);
        bus.mem_req        = 1'b0;
        bus.data_mem_we    = WE_LOAD;
        bus.data_mem_addr  = 32'h0;
        bus.data_mem_wdata = 32'h0;
        err_exp = err_exp | ~legal | (legal & oor0);
        if (split) begin
            #1;
            check({name, "/busy_T1"}, {31'd0, bus.mem_busy}, 32'd1);
            check({name, "/err_T1"}, {31'd0, bus.mem_err}, {31'd0, err_exp});
            @(negedge clk);
            err_exp = err_exp | oor1;
        end
        #1;
        check({name, "/busy_end"}, {31'd0, bus.mem_busy}, 32'd0);
        check({name, "/err"}, {31'd0, bus.mem_err}, {31'd0, err_exp});
        e = sb_q.pop_front();
        check({name, "/data"}, bus.data_mem_out & e.msk, e.exp);
    endtask

    // Hold reset for two cycles and check the reset state.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_exp = 32'h0;
        last_msk = 32'hFFFF_FFFF;
        err_exp  = 1'b0;
        #1;
        check("rst/out", bus.data_mem_out, 32'h0);
        check("rst/busy", {31'd0, bus.mem_busy}, 32'd0);
        check("rst/err", {31'd0, bus.mem_err}, 32'd0);
    endtask

    // Watchdog so a broken design cannot stall the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[13];
        tbl[0]  = '{WE_SW,   32'h100, 32'hDEADBEEF, 32'h0,        32'h0};
        tbl[1]  = '{WE_LOAD, 32'h100, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF};
        tbl[2]  = '{WE_SW,   32'h200, 32'h11223344, 32'h0,        32'h0};
        tbl[3]  = '{WE_SB,   32'h201, 32'h000000AA, 32'h0,        32'h0};
        tbl[4]  = '{WE_SH,   32'h202, 32'h0000BBCC, 32'h0,        32'h0};
        tbl[5]  = '{WE_LOAD, 32'h200, 32'h0,        32'hBBCCAA44, 32'hFFFFFFFF};
        tbl[6]  = '{WE_SW,   32'h303, 32'h55667788, 32'h0,        32'h0};
        tbl[7]  = '{WE_LOAD, 32'h300, 32'h0,        32'h88000000, 32'hFF000000};
        tbl[8]  = '{WE_LOAD, 32'h304, 32'h0,        32'h00556677, 32'h00FFFFFF};
        tbl[9]  = '{WE_LOAD, 32'h303, 32'h0,        32'h55667788, 32'hFFFFFFFF};
        tbl[10] = '{WE_SH,   32'h3FF, 32'h0000BEEF, 32'h0,        32'h0};
        tbl[11] = '{WE_LOAD, 32'h3FE, 32'h0,        32'h00BEEF00, 32'h00FFFF00};
        tbl[12] = '{WE_SB,   32'h403, 32'h0000005A, 32'h0,        32'h0};

        bus.mem_req        = 1'b0;
        bus.data_mem_we    = WE_LOAD;
        bus.data_mem_addr  = 32'h0;
        bus.data_mem_wdata = 32'h0;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            issue($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp, tbl[i].msk);
        end
        issue("ld400", WE_LOAD, 32'h400, 32'h0, 32'h5A0000BE, 32'hFF0000FF);

        // Strobe during the second half must be ignored.
        issue("sw700", WE_SW, 32'h700, 32'h12345678, 32'h0, 32'h0);
        bus.mem_req        = 1'b1;
        bus.data_mem_we    = WE_SW;
        bus.data_mem_addr  = 32'h603;
        bus.data_mem_wdata = 32'h01020304;
        #1;
        check("busy2/busy_T", {31'd0, bus.mem_busy}, 32'd1);
        @(negedge clk);
        bus.data_mem_we    = WE_SB;
        bus.data_mem_addr  = 32'h700;
        bus.data_mem_wdata = 32'h000000EE;
        #1;
        check("busy2/busy_T1", {31'd0, bus.mem_busy}, 32'd1);
        @(negedge clk);
        bus.mem_req        = 1'b0;
        bus.data_mem_we    = WE_LOAD;
        bus.data_mem_addr  = 32'h0;
        bus.data_mem_wdata = 32'h0;
        #1;
        check("busy2/busy_T2", {31'd0, bus.mem_busy}, 32'd0);
        check("busy2/out_hold", bus.data_mem_out & last_msk, last_exp);
        issue("ld700", WE_LOAD, 32'h700, 32'h0, 32'h12345678, 32'hFFFFFFFF);
        issue("ld603", WE_LOAD, 32'h603, 32'h0, 32'h01020304, 32'hFFFFFFFF);

        // Illegal code: no write, output held, sticky error.
        issue("illegal", 3'b011, 32'h100, 32'h0, 32'h0, 32'h0);
        issue("ld100a", WE_LOAD, 32'h100, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF);
        do_reset();

        // Range errors: second-half error rises a cycle late; out-of-range stores do not alias.
        issue("sw3ffc", WE_SW, 32'h3FFC, 32'h11223344, 32'h0, 32'h0);
        issue("ld3ffe", WE_LOAD, 32'h3FFE, 32'h0, 32'h00001122, 32'hFFFFFFFF);
        issue("sw000", WE_SW, 32'h0, 32'h0BADF00D, 32'h0, 32'h0);
        issue("sw4000", WE_SW, 32'h4000, 32'hFFFFFFFF, 32'h0, 32'h0);
        issue("ld000", WE_LOAD, 32'h0, 32'h0, 32'h0BADF00D, 32'hFFFFFFFF);
        issue("ld4000", WE_LOAD, 32'h4000, 32'h0, 32'h0, 32'hFFFFFFFF);

        // Reset in the middle of a split store.
        issue("sw0fc", WE_SW, 32'h0FC, 32'h0, 32'h0, 32'h0);
        bus.mem_req        = 1'b1;
        bus.data_mem_we    = WE_SW;
        bus.data_mem_addr  = 32'h0FE;
        bus.data_mem_wdata = 32'hA1B2C3D4;
        @(negedge clk);
        bus.mem_req        = 1'b0;
        bus.data_mem_we    = WE_LOAD;
        bus.data_mem_addr  = 32'h0;
        bus.data_mem_wdata = 32'h0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_exp = 32'h0;
        last_msk = 32'hFFFF_FFFF;
        err_exp  = 1'b0;
        #1;
        check("midrst/busy", {31'd0, bus.mem_busy}, 32'd0);
        check("midrst/out", bus.data_mem_out, 32'h0);
        check("midrst/err", {31'd0, bus.mem_err}, 32'd0);
        issue("ld0fc", WE_LOAD, 32'h0FC, 32'h0, 32'hC3D40000, 32'hFFFFFFFF);
        issue("ld100b", WE_LOAD, 32'h100, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
